// File: rtl/bin_to_gray_enc.sv
// bin_to_gray_enc: binary-to-Gray encoder with a 2-entry output FIFO and an internal counter source.
// Define BIN_TO_GRAY_PARITY_EN to add out_parity, the XOR of each source word, stored with its entry.
module bin_to_gray_enc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_binary,
  input  logic             src_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] cnt_value
`ifdef BIN_TO_GRAY_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  localparam int DEPTH = 2;
`ifdef BIN_TO_GRAY_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  typedef enum logic [$clog2(DEPTH+1)-1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, src, enc;
  logic [EW-1:0] head_q, head_d, tail_q, tail_d, entry;
  logic push, pop;
  always_comb begin
    src = src_sel ? cnt_q : in_binary;
    enc = src ^ (src >> 1);
`ifdef BIN_TO_GRAY_PARITY_EN
    entry = {^src, enc};
`else
    entry = enc;
`endif
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    cnt_d = cnt_q + WIDTH'(push && src_sel);
    // head is always the oldest word; tail only fills when a second word waits
    head_d = (push && (state_q == EMPTY || pop)) ? entry
           : (pop && state_q == FULL) ? tail_q : head_q;
    tail_d = (push && !pop && state_q == ONE) ? entry : tail_q;
    state_d = (push && !pop) ? (state_q == EMPTY ? ONE : FULL)
            : (pop && !push) ? (state_q == FULL ? ONE : EMPTY) : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign in_ready = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_gray = head_q[WIDTH-1:0];
  assign cnt_value = cnt_q;
`ifdef BIN_TO_GRAY_PARITY_EN
  assign out_parity = head_q[WIDTH];
`endif
endmodule

// File: tb/tb_bin_to_gray_enc.sv
// tb_bin_to_gray_enc: directed-vector self-checking bench for bin_to_gray_enc (WIDTH=4).
module tb_bin_to_gray_enc;
  logic clk = 0, rst = 1, in_valid = 0, src_sel = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [3:0] in_binary = '0, out_gray, cnt_value, prev;
`ifdef BIN_TO_GRAY_PARITY_EN
  logic out_parity;
`endif
  int checks = 0, failures = 0;
  bin_to_gray_enc #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_binary(in_binary), .src_sel(src_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_gray(out_gray), .cnt_value(cnt_value)
`ifdef BIN_TO_GRAY_PARITY_EN
    , .out_parity(out_parity)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    step();
    rst = 0;
  endtask
  logic [3:0] v32 [4] = '{4'b1011, 4'b0111, 4'b1111, 4'b0000};
  logic [3:0] g32 [4] = '{4'b1110, 4'b0100, 4'b1000, 4'b0000};
  logic [3:0] g35 [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  initial begin
    step();
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_gray", out_gray, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", cnt_value, 0);
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_binary = v32[i];
      step();
      chk("stream_gray", out_gray, g32[i]);
      chk("stream_valid", out_valid, 1);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 0;
    step();
    chk("stream_drain", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    in_binary = 3;
    step();
    in_binary = 5;
    step();
    in_valid = 0;
    chk("full_ready", in_ready, 0);
    chk("full_gray", out_gray, 4'b0010);
    step();
    chk("full_hold_gray", out_gray, 4'b0010);
    chk("full_hold_valid", out_valid, 1);
    out_ready = 1;
    chk("pop1_gray", out_gray, 4'b0010);
    step();
    chk("pop2_gray", out_gray, 4'b0111);
    chk("pop2_ready", in_ready, 1);
    step();
    chk("pop_empty", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    in_binary = 3;
    step();
    in_binary = 5;
    step();
    out_ready = 1;
    in_binary = 6;
    chk("fullpush_ready", in_ready, 0);
    step();
    chk("fullpop_gray", out_gray, 4'b0111);
    chk("fullpop_ready", in_ready, 1);
    step();
    chk("pushpop_gray", out_gray, 4'b0101);
    chk("pushpop_ready", in_ready, 1);
    in_valid = 0;
    step();
    chk("pushpop_empty", out_valid, 0);
    do_reset();
    src_sel = 1;
    in_valid = 1;
    prev = 4'hF;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("cnt_gray", out_gray, g35[i]);
      if (i > 0) chk("cnt_onebit", 16'($countones(out_gray ^ prev)), 1);
      prev = out_gray;
    end
    in_valid = 0;
    chk("cnt_wrap", cnt_value, 1);
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 9; i++) step();
    src_sel = 0;
    out_ready = 0;
    step();
    in_valid = 0;
    step();
    chk("pre_rst_cnt", cnt_value, 9);
    chk("pre_rst_ready", in_ready, 0);
    rst = 1;
    in_valid = 1;
    step();
    rst = 0;
    in_valid = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", cnt_value, 0);
    chk("mid_rst_gray", out_gray, 0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", out_valid, 0);
    end
`ifdef BIN_TO_GRAY_PARITY_EN
    in_valid = 1;
    in_binary = 4'b1011;
    step();
    chk("par1_gray", out_gray, 4'b1110);
    chk("par1", out_parity, 1);
    in_binary = 4'b0110;
    step();
    chk("par0_gray", out_gray, 4'b0101);
    chk("par0", out_parity, 0);
    in_valid = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin_to_gray_enc.md
BIN_TO_GRAY_ENC -- requirements
Module: bin_to_gray_enc

Interface
REQ-001 Parameter WIDTH, default 4, code width in bits; legal range 2..16.
REQ-002 Parameter DEPTH, fixed at 2, output buffer entries; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  producer offers a word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_binary  input  WIDTH  binary word to encode.
REQ-008 src_sel  input  1  0 selects in_binary as source; 1 selects the internal binary counter.
REQ-009 out_valid  output  1  out_gray holds a valid word.
REQ-010 out_ready  input  1  consumer accepts the word this cycle.
REQ-011 out_gray  output  WIDTH  Gray-coded word.
REQ-012 cnt_value  output  WIDTH  current internal counter value, binary.

Function
REQ-013 Encoding SHALL be g[WIDTH-1] = b[WIDTH-1] and g[i] = b[i+1] XOR b[i] for i < WIDTH-1.
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 Source word on push SHALL be in_binary when src_sel=0, or cnt_value when src_sel=1; src_sel is sampled on the push cycle only.
REQ-016 Encoding SHALL happen before storage, so the buffer holds Gray words.
REQ-017 Buffer SHALL be a 2-entry FIFO with occupancy states EMPTY(0), ONE(1) and FULL(2).
REQ-018 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-019 in_ready SHALL equal (state != FULL), derived from registered state only, with no combinational path from out_ready.
REQ-020 In FULL, in_ready SHALL be 0 even when out_ready=1; no push is allowed in that cycle.
REQ-021 out_valid SHALL equal (state != EMPTY); out_gray SHALL present the oldest entry.
REQ-022 Latency: a word pushed in cycle N into EMPTY SHALL appear on out_gray with out_valid=1 in cycle N+1.
REQ-023 While out_valid=1 and out_ready=0, out_gray and out_valid SHALL hold stable.
REQ-024 Word order SHALL be preserved, with no loss or duplication.
REQ-025 The internal counter SHALL increment by 1 only on a push with src_sel=1, wrapping from 2^WIDTH-1 to 0.
REQ-026 The internal counter SHALL hold on a push with src_sel=0 and when no push occurs.

Reset
REQ-027 With rst=1 at a rising edge, state SHALL go to EMPTY, counter to 0 and buffer contents to 0.
REQ-028 During and after reset: out_valid=0, out_gray=0, in_ready=1, cnt_value=0 (and out_parity=0 when present).
REQ-029 Reset mid-transfer SHALL discard all buffered words; a push asserted in the reset cycle is ignored.

Configuration
REQ-030 Macro BIN_TO_GRAY_PARITY_EN, when defined, SHALL add port out_parity (output, 1 bit) equal to the XOR of all bits of the source binary word, stored with each entry and aligned with out_gray.
REQ-031 With BIN_TO_GRAY_PARITY_EN undefined, out_parity and its storage SHALL not exist; all other behaviour is identical.

Verification
REQ-032 WIDTH=4, src_sel=0, out_ready=1; push 4'b1011, 4'b0111, 4'b1111, 4'b0000 on consecutive cycles -> out_gray 4'b1110, 4'b0100, 4'b1000, 4'b0000, each one cycle after its push; in_ready stays 1.
REQ-033 out_ready=0; push 3 then 5 -> state FULL, in_ready=0, out_gray=4'b0010 held. Raise out_ready -> out_gray 4'b0010 then 4'b0111; in_ready returns to 1 the cycle after the first pop.
REQ-034 Hold FULL with out_ready=1 and in_valid=1 -> exactly one pop and no push that cycle. Next cycle is ONE with simultaneous push and pop -> occupancy stays ONE.
REQ-035 src_sel=1, out_ready=1, 17 consecutive pushes from reset -> out_gray 0000, 0001, 0011, 0010, ..., 1000, then 0000 on wrap. cnt_value ends at 1. Every adjacent output pair differs in exactly one bit.
REQ-036 Buffer FULL, counter=9, assert rst for one cycle -> out_valid=0, in_ready=1, cnt_value=0 the following cycle, and no stale word emerges afterwards.
REQ-037 With BIN_TO_GRAY_PARITY_EN defined, push 4'b1011 -> out_parity=1 alongside out_gray=4'b1110; push 4'b0110 -> out_parity=0.
